pipeline_sequencer: RTL

Central stall/flush sequencer for the 5-stage MIPS pipeline. It merges the hazard unit's stall request, ID-stage branch/jump redirects and a multi-cycle data-memory handshake into one consistent set of per-stage write-enable and flush controls. It also enforces a post-reset pipeline boot flush and a data-memory timeout. It sits between the hazard detection unit / data memory and the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

---
 rtl/pipeline_sequencer.sv | 96 +++++++++
 1 files changed

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: merges hazard, branch/jump and data-memory handshake into per-stage write/flush controls; PIPE_PERF_CNT_EN adds stall/flush counters
module pipeline_sequencer #(
  parameter int BOOT_CYCLES = 2,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       HazStall,
  input  logic       BranchTaken_ID,
  input  logic       Jump_ID,
  input  logic       MemReq_MEM,
  input  logic       MemAck,
  output logic       PCWrite,
  output logic       IFIDWrite,
  output logic       IFIDFlush,
  output logic       IDEXWrite,
  output logic       IDEXFlush,
  output logic       EXMEMWrite,
  output logic       MEMWBFlush,
  output logic       MemTimeout,
  output logic [1:0] SeqState
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
`endif
);
  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0] r_state;
  logic [3:0] r_boot;
  logic [7:0] r_wait;
  logic       w_boot, w_run, w_wait, w_err, w_memstall, w_haz, w_br;

  // decode the current condition; memory freeze outranks hazard, hazard outranks redirect
  always_comb begin
    w_boot     = r_state == S_BOOT;
    w_run      = r_state == S_RUN;
    w_wait     = r_state == S_WAIT;
    w_err      = r_state == S_ERR;
    w_memstall = (w_run && MemReq_MEM && !MemAck) || (w_wait && !MemAck);
    w_haz      = w_run && !w_memstall && HazStall;
    w_br       = w_run && !w_memstall && !HazStall && (BranchTaken_ID || Jump_ID);
    PCWrite    = !(w_boot || w_err || w_memstall || w_haz);
    IFIDWrite  = PCWrite;
    IFIDFlush  = w_boot || w_br;
    IDEXWrite  = !(w_err || w_memstall);
    IDEXFlush  = w_boot || w_haz;
    EXMEMWrite = !(w_err || w_memstall);
    MEMWBFlush = w_boot || w_memstall;
    MemTimeout = w_err;
    SeqState   = r_state;
  end

  // state, boot counter and memory wait counter; ERROR is left only through reset
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_BOOT;
      r_boot  <= '0;
      r_wait  <= '0;
    end else begin
      case (r_state)
        S_BOOT: begin
          r_boot <= r_boot + 4'd1;
          if (r_boot == 4'(BOOT_CYCLES - 1)) r_state <= S_RUN;
        end
        S_RUN: if (MemReq_MEM && !MemAck) begin
          r_state <= S_WAIT;
          r_wait  <= 8'd1;
        end
        S_WAIT: begin
          if (MemAck) r_state <= S_RUN;
          else if (r_wait == 8'(MEM_TIMEOUT)) r_state <= S_ERR;
          else r_wait <= r_wait + 8'd1;
        end
        default: r_state <= S_ERR;
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // count frozen-PC cycles while running and IF/ID flushes caused by redirects
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if ((w_run || w_wait) && !PCWrite) StallCount <= StallCount + 32'd1;
      if (w_run && IFIDFlush) FlushCount <= FlushCount + 32'd1;
    end
  end
`endif
endmodule
